// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst sequencer; host CMD/WD/RD valid-ready handshakes in, memory WE/EN(active-low)/A/D strobes out, Q sampled into RD
module mem_burst_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WR,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [AW-1:0] CMD_LEN,
  input  logic          WD_VALID,
  output logic          WD_READY,
  input  logic [DW-1:0] WD,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [DW-1:0] RD,
  output logic          BUSY,
  output logic          DONE,
  output logic          WE,
  output logic          EN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);
  typedef enum logic [3:0] {
    IDLE, W_WAIT, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, R_OUT, FIN
  } state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr, addr_nx, rem, rem_nx, a_nx;
  logic [DW-1:0] d_nx, rd_nx;
  logic          we_nx, en_nx, rd_valid_nx, done_nx, last;
  assign CMD_READY = state == IDLE;
  assign WD_READY  = state == W_WAIT;
  assign BUSY      = state != IDLE;
  assign last      = rem == '0;
  always_comb begin
    state_nx    = state;
    addr_nx     = addr;
    rem_nx      = rem;
    a_nx        = A;
    d_nx        = D;
    rd_nx       = RD;
    rd_valid_nx = RD_VALID;
    en_nx       = EN;
    we_nx       = 1'b0;
    done_nx     = 1'b0;
    case (state)
      IDLE: if (CMD_VALID) begin
        addr_nx  = CMD_ADDR;
        rem_nx   = CMD_LEN;
        a_nx     = CMD_ADDR;
        en_nx    = 1'b0;
        state_nx = CMD_WR ? W_WAIT : R_ADDR;
      end
      W_WAIT: if (WD_VALID) begin
        d_nx     = WD;
        a_nx     = addr;
        state_nx = W_SETUP;
      end
      W_SETUP: begin
        we_nx    = 1'b1;
        state_nx = W_STROBE;
      end
      W_STROBE: state_nx = W_HOLD;
      W_HOLD: begin
        done_nx  = last;
        rem_nx   = last ? rem : rem - 1'b1;
        addr_nx  = last ? addr : addr + 1'b1;
        state_nx = last ? FIN : W_WAIT;
      end
      R_ADDR: begin
        a_nx     = addr;
        state_nx = R_SAMPLE;
      end
      R_SAMPLE: begin
        rd_nx       = Q;
        rd_valid_nx = 1'b1;
        state_nx    = R_OUT;
      end
      R_OUT: if (RD_READY) begin
        rd_valid_nx = 1'b0;
        done_nx     = last;
        rem_nx      = last ? rem : rem - 1'b1;
        addr_nx     = last ? addr : addr + 1'b1;
        state_nx    = last ? FIN : R_ADDR;
      end
      FIN: begin
        en_nx    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      addr     <= '0;
      rem      <= '0;
      A        <= '0;
      D        <= '0;
      RD       <= '0;
      RD_VALID <= 1'b0;
      WE       <= 1'b0;
      EN       <= 1'b1;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      rem      <= rem_nx;
      A        <= a_nx;
      D        <= d_nx;
      RD       <= rd_nx;
      RD_VALID <= rd_valid_nx;
      WE       <= we_nx;
      EN       <= en_nx;
      DONE     <= done_nx;
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized self-checking bench with a word-array memory and a command-level reference model
module tb_mem_burst_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int N  = 1 << AW;
  logic          CLK = 0, RSTN = 0;
  logic          CMD_VALID = 0, CMD_WR = 0, WD_VALID = 0, RD_READY = 0;
  logic [AW-1:0] CMD_ADDR = '0, CMD_LEN = '0;
  logic [DW-1:0] WD = '0;
  logic          CMD_READY, WD_READY, RD_VALID, BUSY, DONE, WE, EN;
  logic [DW-1:0] RD, D, Q;
  logic [AW-1:0] A;
  mem_burst_ctrl #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD(WD),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD(RD), .BUSY(BUSY), .DONE(DONE), .WE(WE),
    .EN(EN), .A(A), .D(D), .Q(Q)
  );
  always #5 CLK = ~CLK;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] ref_mem [N];
  assign Q = mem[A];
  typedef struct { int a; int d; int c; } wr_t;
  wr_t wr_q [$];
  int  passed = 0, total = 0, cyc = 0, done_cnt = 0, consec_viol = 0, we_in_read = 0;
  bit  reading = 0, we_prev = 0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (WE && !EN) begin
      mem[A] <= D;
      wr_q.push_back(wr_t'{int'(A), int'(D), cyc});
    end
  end
  always @(negedge CLK) begin
    if (WE && we_prev) consec_viol <= consec_viol + 1;
    if (WE && reading) we_in_read <= we_in_read + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    we_prev <= WE;
  end
  task automatic accept(input bit wr, input logic [AW-1:0] ad, input logic [AW-1:0] ln, output int c);
    int n = 0;
    CMD_VALID = 1; CMD_WR = wr; CMD_ADDR = ad; CMD_LEN = ln;
    while (!CMD_READY && n < 20) begin @(negedge CLK); n++; end
    if (!CMD_READY) begin total++; $display("FAIL cmd_accept: CMD_READY=%0b required 1", CMD_READY); end
    @(negedge CLK);
    c = cyc;
    CMD_VALID = 0;
  endtask
  task automatic write_burst(input logic [AW-1:0] ad, input logic [AW-1:0] ln, input logic [DW-1:0] dat [N],
                             input int stall_at, input int stall_n);
    int c;
    accept(1, ad, ln, c);
    for (int i = 0; i <= int'(ln); i++) begin
      int n = 0;
      if (i == stall_at) begin
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        bit bad = 0;
        WD_VALID = 0;
        while (!WD_READY && n < 20) begin @(negedge CLK); n++; end
        sa = A; sd = D;
        repeat (stall_n) begin
          @(negedge CLK);
          if (WE || A !== sa || D !== sd) bad = 1;
        end
        total++;
        if (bad) $display("FAIL wd_stall: WE=%0b A=%0d D=%0d required WE=0 A=%0d D=%0d", WE, A, D, sa, sd);
        else passed++;
        n = 0;
      end
      WD = dat[i]; WD_VALID = 1;
      while (!WD_READY && n < 40) begin @(negedge CLK); n++; end
      if (!WD_READY) begin total++; $display("FAIL wd_timeout: WD_READY=%0b required 1 word %0d", WD_READY, i); end
      @(negedge CLK);
    end
    WD_VALID = 0;
    for (int i = 0; i <= int'(ln); i++) ref_mem[(int'(ad) + i) % N] = dat[i];
    repeat (8) @(negedge CLK);
  endtask
  task automatic read_burst(input logic [AW-1:0] ad, input logic [AW-1:0] ln, input int stall_at, input int stall_n,
                            output logic [DW-1:0] got [N], output int got_a [N], output int lat);
    int c;
    lat = -1;
    RD_READY = 1; reading = 1;
    accept(0, ad, ln, c);
    for (int i = 0; i <= int'(ln); i++) begin
      int n = 0;
      while (!RD_VALID && n < 20) begin @(negedge CLK); n++; end
      if (!RD_VALID) begin total++; $display("FAIL rd_timeout: RD_VALID=%0b required 1 word %0d", RD_VALID, i); end
      if (i == 0) lat = cyc - c;
      got[i] = RD; got_a[i] = int'(A);
      if (i == stall_at) begin
        bit bad = 0;
        RD_READY = 0;
        repeat (stall_n) begin
          @(negedge CLK);
          if (!RD_VALID || RD !== got[i]) bad = 1;
        end
        total++;
        if (bad) $display("FAIL rd_stall: RD_VALID=%0b RD=%0d required 1/%0d", RD_VALID, RD, got[i]);
        else passed++;
        RD_READY = 1;
      end
      @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    reading = 0;
  endtask
  task automatic test_reset;
    RSTN = 0;
    repeat (3) @(negedge CLK);
    RSTN = 1;
    @(negedge CLK);
    total++; if (CMD_READY !== 1'b1) $display("FAIL rst_cmd_ready: got %0b required 1", CMD_READY); else passed++;
    total++; if (EN !== 1'b1) $display("FAIL rst_en: got %0b required 1", EN); else passed++;
    total++; if (WE !== 1'b0) $display("FAIL rst_we: got %0b required 0", WE); else passed++;
    total++; if (A !== '0) $display("FAIL rst_a: got %0d required 0", A); else passed++;
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) $display("FAIL rst_busy_done: got %0b/%0b required 0/0", BUSY, DONE); else passed++;
    total++; if (D !== '0 || RD_VALID !== 1'b0 || WD_READY !== 1'b0) $display("FAIL rst_misc: D=%0d RD_VALID=%0b WD_READY=%0b required 0", D, RD_VALID, WD_READY); else passed++;
  endtask
  task automatic test_write_burst;
    logic [DW-1:0] dat [N];
    int d0;
    for (int i = 0; i < N; i++) dat[i] = DW'(64 + i);
    wr_q.delete(); d0 = done_cnt;
    write_burst(0, 3, dat, -1, 0);
    total++; if (wr_q.size() != 4) $display("FAIL wr_count: got %0d required 4", wr_q.size()); else passed++;
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i].a != i || wr_q[i].d != 64 + i) $display("FAIL wr_word%0d: got A=%0d D=%0d required A=%0d D=%0d", i, wr_q[i].a, wr_q[i].d, i, 64 + i);
      else passed++;
      if (i > 0) begin
        total++;
        if (wr_q[i].c - wr_q[i-1].c != 4) $display("FAIL wr_spacing%0d: got %0d required 4", i, wr_q[i].c - wr_q[i-1].c);
        else passed++;
      end
    end
    total++; if (done_cnt - d0 != 1) $display("FAIL wr_done: got %0d pulses required 1", done_cnt - d0); else passed++;
  endtask
  task automatic test_read_burst;
    logic [DW-1:0] got [N];
    int ga [N];
    int lat, d0, w0;
    d0 = done_cnt; w0 = we_in_read;
    read_burst(0, 3, -1, 0, got, ga, lat);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== ref_mem[i]) $display("FAIL rd_word%0d: got %0d required %0d", i, got[i], ref_mem[i]); else passed++;
    end
    total++; if (lat != 2) $display("FAIL rd_latency: got %0d required 2", lat); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL rd_done: got %0d pulses required 1", done_cnt - d0); else passed++;
    total++; if (we_in_read != w0) $display("FAIL rd_we: got %0d WE cycles required 0", we_in_read - w0); else passed++;
  endtask
  task automatic test_wrap;
    logic [DW-1:0] dat [N];
    logic [DW-1:0] got [N];
    int ga [N];
    int lat;
    dat[0] = 9; dat[1] = 0; dat[2] = 0; dat[3] = 0;
    wr_q.delete();
    write_burst(3, 0, dat, -1, 0);
    total++; if (wr_q.size() != 1 || wr_q[0].a != 3 || wr_q[0].d != 9) $display("FAIL wrap_write: got %0d writes required one at A=3 D=9", wr_q.size()); else passed++;
    read_burst(3, 1, -1, 0, got, ga, lat);
    total++; if (ga[0] != 3 || ga[1] != 0) $display("FAIL wrap_addr: got %0d,%0d required 3,0", ga[0], ga[1]); else passed++;
    total++; if (got[0] !== 8'd9 || got[1] !== 8'd64) $display("FAIL wrap_data: got %0d,%0d required 9,64", got[0], got[1]); else passed++;
  endtask
  task automatic test_backpressure;
    logic [DW-1:0] dat [N];
    logic [DW-1:0] got [N];
    int ga [N];
    int lat;
    for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
    wr_q.delete();
    write_burst(1, 2, dat, 1, 5);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= wr_q.size() || wr_q[i].a != (1 + i) % N || wr_q[i].d != int'(dat[i]))
        $display("FAIL bp_write%0d: got %0d writes required A=%0d D=%0d", i, wr_q.size(), (1 + i) % N, dat[i]);
      else passed++;
    end
    read_burst(1, 2, 1, 4, got, ga, lat);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== dat[i]) $display("FAIL bp_read%0d: got %0d required %0d", i, got[i], dat[i]); else passed++;
    end
  endtask
  task automatic test_reset_mid;
    int c, n, d0;
    d0 = done_cnt; n = 0;
    accept(1, 2, 0, c);
    WD = DW'($urandom); WD_VALID = 1;
    while (!WE && n < 20) begin @(negedge CLK); n++; end
    WD_VALID = 0;
    total++; if (!WE) $display("FAIL mid_strobe: WE=%0b required 1", WE); else passed++;
    #2 RSTN = 0;
    #1;
    total++; if (WE !== 1'b0 || EN !== 1'b1) $display("FAIL mid_async: WE=%0b EN=%0b required 0/1", WE, EN); else passed++;
    @(negedge CLK);
    RSTN = 1;
    @(negedge CLK);
    total++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0) $display("FAIL mid_idle: CMD_READY=%0b BUSY=%0b required 1/0", CMD_READY, BUSY); else passed++;
    repeat (5) @(negedge CLK);
    total++; if (done_cnt != d0) $display("FAIL mid_done: got %0d pulses required 0", done_cnt - d0); else passed++;
  endtask
  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      logic [DW-1:0] dat [N];
      logic [DW-1:0] got [N];
      int ga [N];
      int lat;
      logic [AW-1:0] ad, ln, rad;
      ad = AW'($urandom); ln = AW'($urandom); rad = AW'($urandom);
      for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
      wr_q.delete();
      write_burst(ad, ln, dat, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
      total++;
      if (wr_q.size() != int'(ln) + 1) $display("FAIL rnd_wr_count%0d: got %0d required %0d", it, wr_q.size(), int'(ln) + 1);
      else passed++;
      for (int i = 0; i < wr_q.size() && i <= int'(ln); i++) begin
        total++;
        if (wr_q[i].a != (int'(ad) + i) % N || wr_q[i].d != int'(dat[i]))
          $display("FAIL rnd_wr%0d_%0d: got A=%0d D=%0d required A=%0d D=%0d", it, i, wr_q[i].a, wr_q[i].d, (int'(ad) + i) % N, dat[i]);
        else passed++;
      end
      read_burst(rad, 3, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), got, ga, lat);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== ref_mem[(int'(rad) + i) % N] || ga[i] != (int'(rad) + i) % N)
          $display("FAIL rnd_rd%0d_%0d: got A=%0d RD=%0d required A=%0d RD=%0d", it, i, ga[i], got[i], (int'(rad) + i) % N, ref_mem[(int'(rad) + i) % N]);
        else passed++;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    @(negedge CLK);
    test_reset;
    test_write_burst;
    test_read_burst;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_random;
    total++; if (consec_viol != 0) $display("FAIL we_consecutive: got %0d required 0", consec_viol); else passed++;
    total++; if (we_in_read != 0) $display("FAIL we_in_read: got %0d required 0", we_in_read); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Bus-side initiator for the cascaded word memory: it generates the WE/EN/A/D strobes and samples Q. A host issues burst write or burst read commands over valid/ready handshakes. The block then sequences the per-word memory cycles, with address auto-increment and wrap-around. It sits between host logic and the memory array.

Parameters:
DW, 8, memory data width; equals the cascaded word width.
AW, 2, memory address width; the array holds 2^AW words.

Ports:
CLK  in  1  clock, rising-edge.
RSTN  in  1  reset, asynchronous assert, active-low.
CMD_VALID  in  1  host command valid.
CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high at a rising edge.
CMD_WR  in  1  1 = burst write, 0 = burst read; sampled only at accept.
CMD_ADDR  in  AW  start address.
CMD_LEN  in  AW  burst length minus 1; a burst is CMD_LEN+1 words.
WD_VALID  in  1  write-data valid.
WD_READY  out  1  write-data ready.
WD  in  DW  write data.
RD_VALID  out  1  read-data valid.
RD_READY  in  1  read-data ready.
RD  out  DW  read data.
BUSY  out  1  high whenever state is not IDLE.
DONE  out  1  one-cycle pulse at burst completion.
WE  out  1  memory write enable, active-high.
EN  out  1  memory enable, active-low (0 = selected).
A  out  AW  memory address.
D  out  DW  memory write data.
Q  in  DW  memory read data; combinational from A.

Behaviour:
- Reset (RSTN=0, effective immediately, no clock needed): state IDLE, WE=0, EN=1, A=0, D=0, RD=0, RD_VALID=0, DONE=0, BUSY=0, CMD_READY=1, WD_READY=0. Internal address counter and remaining-word counter both 0.
- Decoded outputs: CMD_READY = (state==IDLE); WD_READY = (state==W_WAIT); BUSY = (state!=IDLE). All other outputs are registered.
- States: IDLE, W_WAIT, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, R_OUT, FIN.
- IDLE: on accept, load addr<=CMD_ADDR, rem<=CMD_LEN, EN<=0, A<=CMD_ADDR. Go to W_WAIT if CMD_WR=1, else R_ADDR.
- W_WAIT: on WD handshake, D<=WD and A<=addr, then go to W_SETUP. While stalled, WE=0 and A/D are held.
- W_SETUP: WE=0 (address/data setup cycle), then W_STROBE.
- W_STROBE: WE=1 for exactly one cycle, then W_HOLD.
- W_HOLD: WE=0, A and D held. If rem==0 go to FIN. Otherwise rem<=rem-1, addr<=addr+1, go to W_WAIT.
- Write throughput: one word per 4 cycles with WD_VALID held high.
- R_ADDR: A<=addr, WE=0, EN=0, then R_SAMPLE.
- R_SAMPLE: settle cycle. At its closing edge, RD<=Q and RD_VALID<=1, then R_OUT.
- Read latency: RD_VALID rises two edges after the accepting edge.
- R_OUT: RD and RD_VALID are held until RD_READY=1. On the handshake edge RD_VALID<=0. If rem==0 go to FIN. Otherwise rem<=rem-1, addr<=addr+1, go to R_ADDR.
- FIN: DONE=1 for one cycle, EN<=1, WE=0, then IDLE.
- Address arithmetic is modulo 2^AW: addr 2^AW-1 increments to 0.
- CMD_LEN = 2^AW-1 sweeps every word exactly once.
- CMD_VALID while busy is ignored. No command queueing.
- WD_VALID outside W_WAIT and RD_READY outside R_OUT have no effect.
- Reset mid-burst: WE falls and EN rises asynchronously, and the burst is abandoned. No DONE is issued.
- WE is never high during any read state, and never high in two consecutive cycles.

Test Plan:
1. Reset held 3 cycles, then released → CMD_READY=1, EN=1, WE=0, A=0, BUSY=0, DONE=0.
2. Write burst CMD_ADDR=0, CMD_LEN=3, WD=64,65,66,67 with WD_VALID held high → four 1-cycle WE pulses at A=0,1,2,3 with D=64..67. Pulses are 4 cycles apart, then one DONE pulse.
3. Read burst CMD_ADDR=0, CMD_LEN=3, RD_READY=1 → RD=64,65,66,67 in order; first RD_VALID two edges after accept; DONE follows; WE stays 0.
4. Wrap: write 1 word (9) at addr 3, then read CMD_ADDR=3, CMD_LEN=1 → A sequence 3,0; RD=9 then 64.
5. Back-pressure: WD_VALID low for 5 cycles mid-burst and RD_READY low for 4 cycles mid-read → WE stays 0 and A/D stay stable while stalled; RD and RD_VALID are held; data order is unchanged.
6. RSTN pulled low during W_STROBE → WE=0 and EN=1 before the next clock edge; after release, CMD_READY=1 and no DONE pulse.
